// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the hazard_ctrl pipeline sequencer.
// State encodings, the zero-register constant and the source-operand compare.
`timescale 1ns/1ps
package hazard_ctrl_pkg;

    typedef enum logic {
        HZ_RUN     = 1'b0,
        HZ_MD_BUSY = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when an ID source operand is actually read and names the load's destination.
    function automatic logic srcHazard(input logic uses, input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_wdog.sv
// Mul/div watchdog counter: cleared while idle, counts while busy and
// flags expiry on the cycle the count reaches MD_TIMEOUT-1.
`timescale 1ns/1ps
module hazard_wdog #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MD_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for IF_ID / ID_EX / PC: load-use stalls, branch redirects
// and mul/div occupancy with watchdog. Optional stall counter: HAZARD_PERF_EN.
`timescale 1ns/1ps
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_md_op,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        md_done,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_start,
    output logic        md_timeout,
    output logic        busy,
    output logic [31:0] stall_cycles
);

    hz_state_e state_q;
    hz_state_e state_d;
    logic      load_use;
    logic      wd_expired;

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      (srcHazard(id_uses_rs, id_rs, ex_rt) ||
                       srcHazard(id_uses_rt, id_rt, ex_rt));

    hazard_wdog #(
        .MD_TIMEOUT(MD_TIMEOUT),
        .CNT_W     (CNT_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == HZ_RUN),
        .en     (state_q == HZ_MD_BUSY),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A branch squashes the ID instruction and a load-use holds it, so neither launches mul/div.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_RUN: begin
                if (!ex_branch_taken && !load_use && id_md_op) begin
                    state_d = HZ_MD_BUSY;
                end
            end
            HZ_MD_BUSY: begin
                if (md_done || wd_expired) begin
                    state_d = HZ_RUN;
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    // Outputs are forced low whenever reset is asserted, independent of the clock.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        md_start    = 1'b0;
        md_timeout  = 1'b0;
        busy        = 1'b0;
        if (rst) begin
            case (state_q)
                HZ_RUN: begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (id_md_op) begin
                        md_start = 1'b1;
                    end
                end
                HZ_MD_BUSY: begin
                    busy = 1'b1;
                    if (md_done) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end else if (wd_expired) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        md_timeout  = 1'b1;
                    end else begin
                        id_ex_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (rst && !pc_write && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table vectors, hand-written multi-cycle
// sequences and randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int TB_TIMEOUT = 12;
`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] idRs;
        logic [4:0] idRt;
        logic       usesRs;
        logic       usesRt;
        logic       mdOp;
        logic       memRead;
        logic [4:0] exRt;
        logic       branch;
        logic       mdDone;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [6:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_uses_rs = 1'b0;
    logic        id_uses_rt = 1'b0;
    logic        id_md_op = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic        ex_branch_taken = 1'b0;
    logic        md_done = 1'b0;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic        md_start, md_timeout, busy;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model state: whether a mul/div is outstanding, how long, and total stalls.
    bit          mBusy = 1'b0;
    int          mCnt = 0;
    longint      mStall = 0;

    hazard_ctrl #(.MD_TIMEOUT(TB_TIMEOUT), .CNT_W(10)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_md_op(id_md_op), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .md_done(md_done),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .md_start(md_start), .md_timeout(md_timeout), .busy(busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input int rs, input int rt, input bit uRs, input bit uRt,
                                 input bit md, input bit rd, input int exr,
                                 input bit br, input bit done);
        stim_t s;
        s.idRs = 5'(rs); s.idRt = 5'(rt); s.usesRs = uRs; s.usesRt = uRt;
        s.mdOp = md; s.memRead = rd; s.exRt = 5'(exr); s.branch = br; s.mdDone = done;
        return s;
    endfunction

    // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush, md_start, md_timeout, busy}.
    function automatic logic [6:0] modelOut(input stim_t s, input logic rstn);
        bit lu;
        lu = s.memRead && (s.exRt != 0) &&
             ((s.usesRs && s.idRs == s.exRt) || (s.usesRt && s.idRt == s.exRt));
        if (!rstn) return 7'b0000000;
        if (!mBusy) begin
            if (s.branch) return 7'b1111000;
            if (lu)       return 7'b0001000;
            if (s.mdOp)   return 7'b1100100;
            return 7'b1100000;
        end
        if (s.mdDone)               return 7'b1100001;
        if (mCnt == TB_TIMEOUT - 1) return 7'b1100011;
        return 7'b0001001;
    endfunction

    task automatic modelAdvance(input stim_t s, input logic rstn, input logic [6:0] e);
        if (!rstn) begin
            mBusy = 1'b0; mCnt = 0; mStall = 0;
        end else begin
            if (!e[6]) mStall++;
            if (!mBusy) begin
                if (e[2]) begin mBusy = 1'b1; mCnt = 0; end
            end else if (s.mdDone || mCnt == TB_TIMEOUT - 1) begin
                mBusy = 1'b0;
            end else begin
                mCnt++;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [6:0] exp);
        logic [6:0]  got;
        logic [31:0] expStall;
        got = {pc_write, if_id_write, if_id_flush, id_ex_flush, md_start, md_timeout, busy};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s outputs got=%b expected=%b at %0t", name, got, exp, $time);
        end
        expStall = PERF_ON ? 32'(mStall) : 32'd0;
        checks++;
        if (stall_cycles !== expStall) begin
            errors++;
            $display("[TB] FAIL %s stall_cycles got=%0d expected=%0d at %0t",
                     name, stall_cycles, expStall, $time);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check mid-cycle, then step the model.
    task automatic applyStimulus(input stim_t s, input logic rstn, input string name,
                                 output logic [6:0] e);
        @(negedge clk);
        rst = rstn;
        id_rs = s.idRs; id_rt = s.idRt; id_uses_rs = s.usesRs; id_uses_rt = s.usesRt;
        id_md_op = s.mdOp; ex_mem_read = s.memRead; ex_rt = s.exRt;
        ex_branch_taken = s.branch; md_done = s.mdDone;
        #1;
        e = modelOut(s, rstn);
        checkOutput(name, e);
        modelAdvance(s, rstn, e);
    endtask

    task automatic doReset();
        logic [6:0] e;
        applyStimulus(mk(0,0,0,0,0,0,0,0,0), 1'b0, "resetHold", e);
        applyStimulus(mk(0,0,0,0,0,0,0,0,0), 1'b0, "resetHold", e);
    endtask

    vec_t vecs[9];
    stim_t idle, luS, mdS, doneS;
    logic [6:0] e;

    initial begin
        idle  = mk(0,0,0,0,0,0,0,0,0);
        luS   = mk(5,0,1,0,0,1,5,0,0);
        mdS   = mk(0,0,0,0,1,0,0,0,0);
        doneS = mk(0,0,0,0,0,0,0,0,1);

        vecs[0] = '{"loadUseRs",    luS,                          7'b0001000};
        vecs[1] = '{"loadUseZero",  mk(0,0,1,0,0,1,0,0,0),        7'b1100000};
        vecs[2] = '{"loadUseRt",    mk(1,7,0,1,0,1,7,0,0),        7'b0001000};
        vecs[3] = '{"rsNotUsed",    mk(7,0,0,0,0,1,7,0,0),        7'b1100000};
        vecs[4] = '{"noLoad",       mk(5,0,1,0,0,0,5,0,0),        7'b1100000};
        vecs[5] = '{"branchOverLu", mk(5,0,1,0,0,1,5,1,0),        7'b1111000};
        vecs[6] = '{"branchOverMd", mk(0,0,0,0,1,0,0,1,0),        7'b1111000};
        vecs[7] = '{"doneInRun",    doneS,                        7'b1100000};
        vecs[8] = '{"luOverMd",     mk(5,0,1,0,1,1,5,0,0),        7'b0001000};

        doReset();
        applyStimulus(idle, 1'b1, "runIdle", e);
        checkValue("runPcWrite", 32'(pc_write), 32'd1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].s, 1'b1, vecs[i].name, e);
            checkValue({vecs[i].name, "Table"},
                       32'({pc_write, if_id_write, if_id_flush, id_ex_flush,
                            md_start, md_timeout, busy}), 32'(vecs[i].exp));
        end

        applyStimulus(luS, 1'b1, "luStall", e);
        applyStimulus(idle, 1'b1, "luRelease", e);
        checkValue("luReleasePc", 32'(pc_write), 32'd1);

        // Mul/div: seven stalled busy cycles, md_done on the eighth.
        applyStimulus(mdS, 1'b1, "mdLaunch", e);
        checkValue("mdStartPulse", 32'(md_start), 32'd1);
        for (int k = 0; k < 7; k++) applyStimulus(mdS, 1'b1, "mdBusy", e);
        applyStimulus(doneS, 1'b1, "mdDone", e);
        checkValue("mdDonePc", 32'(pc_write), 32'd1);
        applyStimulus(idle, 1'b1, "mdAfter", e);
        checkValue("mdAfterBusy", 32'(busy), 32'd0);

        // Watchdog expiry, then md_done coincident with expiry.
        applyStimulus(mdS, 1'b1, "wdLaunch", e);
        for (int k = 0; k < TB_TIMEOUT - 1; k++) applyStimulus(idle, 1'b1, "wdBusy", e);
        applyStimulus(idle, 1'b1, "wdExpire", e);
        checkValue("wdTimeoutPulse", 32'(md_timeout), 32'd1);
        applyStimulus(idle, 1'b1, "wdAfter", e);
        applyStimulus(mdS, 1'b1, "wdLaunch2", e);
        for (int k = 0; k < TB_TIMEOUT - 1; k++) applyStimulus(idle, 1'b1, "wdBusy2", e);
        applyStimulus(doneS, 1'b1, "wdDoneWins", e);
        checkValue("wdDoneNoTimeout", 32'(md_timeout), 32'd0);

        // Asynchronous reset mid MD_BUSY.
        applyStimulus(mdS, 1'b1, "rstLaunch", e);
        applyStimulus(idle, 1'b1, "rstBusy", e);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        mBusy = 1'b0; mCnt = 0; mStall = 0;
        checkOutput("resetAsync", 7'b0000000);
        doReset();
        applyStimulus(idle, 1'b1, "rstAfter", e);
        checkValue("rstAfterPc", 32'(pc_write), 32'd1);

        // Stall accounting: three load-use stalls plus five busy cycles.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(luS, 1'b1, "perfLu", e);
        applyStimulus(mdS, 1'b1, "perfMd", e);
        for (int k = 0; k < 5; k++) applyStimulus(idle, 1'b1, "perfBusy", e);
        applyStimulus(doneS, 1'b1, "perfDone", e);
        applyStimulus(idle, 1'b1, "perfIdle", e);
        checkValue("perfTotal", stall_cycles, PERF_ON ? 32'd8 : 32'd0);

        for (int n = 0; n < 3000; n++) begin
            stim_t r;
            logic  rr;
            r.idRs    = 5'($urandom_range(0, 3));
            r.idRt    = 5'($urandom_range(0, 3));
            r.usesRs  = 1'($urandom);
            r.usesRt  = 1'($urandom);
            r.mdOp    = ($urandom_range(0, 5) == 0);
            r.memRead = 1'($urandom);
            r.exRt    = 5'($urandom_range(0, 3));
            r.branch  = ($urandom_range(0, 7) == 0);
            r.mdDone  = ($urandom_range(0, 13) == 0);
            rr        = ($urandom_range(0, 299) != 0);
            applyStimulus(r, rr, "random", e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the IF_ID / ID_EX / PC stages of the mips32 core.
- Detects load-use hazards, taken-branch redirects and multi-cycle mul/div occupancy.
- Drives PC write enable, IF_ID write/flush and ID_EX bubble insertion. ID_EX has no enable, so a bubble is a zeroed control word.
- Owns the start/done handshake with the mul/div unit, including a timeout watchdog.

Parameters:
- MD_TIMEOUT, 64: max cycles in MD_BUSY without md_done before abort; legal 2..1023.
- CNT_W, 10: width of the watchdog counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_md_op  in  1  ID instruction is mult/multu/div/divu.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination of the load in EX.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- md_done  in  1  mul/div unit result ready, 1-cycle pulse.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF_ID load enable.
- if_id_flush  out  1  IF_ID clear.
- id_ex_flush  out  1  force ID_EX control input to 0 (bubble).
- md_start  out  1  1-cycle launch pulse to the mul/div unit.
- md_timeout  out  1  1-cycle pulse on watchdog abort.
- busy  out  1  state != RUN.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Outputs are combinational (Mealy) from state and inputs; state and counters are registered.
- While rst=0: state=RUN, counter=0, and all outputs are 0.
- Default in RUN with no event: pc_write=1, if_id_write=1, flushes=0, md_start=0.
- load_use = ex_mem_read & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- Priority in RUN, highest first:
  - ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1 (redirect). A load_use or md_op in the same cycle is ignored because the ID instruction is squashed.
  - load_use: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly that cycle. The next cycle re-evaluates; the load is then in MEM, so it normally releases.
  - id_md_op: md_start=1 and the instruction advances into EX normally. Next state is MD_BUSY with counter cleared.
- MD_BUSY:
  - pc_write=0, if_id_write=0, id_ex_flush=1 every cycle. EX holds only bubbles, so ex_branch_taken is ignored.
  - On md_done: this cycle behaves as RUN default (release), next state is RUN. A new id_md_op is not launched in the release cycle.
  - counter increments each cycle. If counter==MD_TIMEOUT-1 and md_done=0: md_timeout=1, release as above, next state RUN.
  - md_done and the timeout in the same cycle: md_done wins, md_timeout=0.
  - md_done arriving in RUN: ignored.
- Reset asserted mid MD_BUSY returns to RUN immediately. No md_start is reissued.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: stall_cycles increments (saturating at 2^32-1) on every cycle with pc_write=0 while rst=1. Cleared on reset.
- Undefined: stall_cycles tied to 0 and no counter logic is generated.

Decomposition:
- parameters.v gets `HZ_RUN=1'b0 and `HZ_MD_BUSY=1'b1 (state encodings) and `REG_ZERO=5'd0.
- One sub-module, hazard_wdog: CNT_W counter with clear/enable and an expired flag at MD_TIMEOUT-1.
- Hazard compare logic stays inline in hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_uses_rs=1, id_rs=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle only; with ex_rt=0 -> no stall.
- Branch priority: ex_branch_taken=1 with the load_use condition also true -> if_id_flush=1, id_ex_flush=1, pc_write=1.
- Mul/div: id_md_op=1 -> md_start pulse 1 cycle; busy=1 and stall for 7 cycles; md_done on the 8th busy cycle -> pc_write=1 that cycle, busy=0 next.
- Watchdog: MD_TIMEOUT=4, no md_done -> md_timeout=1 on the 4th MD_BUSY cycle, then RUN; md_done coincident with expiry -> md_timeout=0.
- Reset: rst low during MD_BUSY -> all outputs 0 immediately; after release, state RUN with pc_write=1.
- HAZARD_PERF_EN: 3 load-use stalls + 5 md busy cycles -> stall_cycles=8; without the macro stall_cycles=0.
